multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Main controller for the multicycle MIPS datapath; the producer end of the dataPath control interface.
//  Decodes Op/Funct from the instruction register and sequences PCEn, IorD, Memwrite, IRWrite,
//  RegDst, MemtoReg, RegWrite, ALUsrcA, ALUsrcB, ALUControl and PCsrc, one state per cycle.
//  Replaces hand-driven control in benches; dataPath ports connect 1:1. Also exposes state and retire count.
// PARAMETERS
//  OP_RTYPE  6'h00  R-type opcode
//  OP_LW     6'h23  load word opcode
//  OP_SW     6'h2B  store word opcode
//  OP_BEQ    6'h04  branch-equal opcode
//  OP_ADDI   6'h08  add-immediate opcode (used only with MC_ADDI_EN)
//  CNT_W     16     width of retired-instruction counter
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      synchronous reset, ACTIVE-LOW
//  Op          in   6      IR[31:26]
//  Funct       in   6      IR[5:0]
//  Zero        in   1      ALU zero flag, same cycle
//  PCEn        out  1      PC write enable
//  IorD        out  1      mem addr select: 0=PC, 1=ALUOut
//  Memwrite    out  1      data memory write enable
//  IRWrite     out  1      instruction register write enable
//  RegDst      out  1      write reg select: 0=rt, 1=rd
//  MemtoReg    out  1      writeback select: 0=ALUOut, 1=MDR
//  RegWrite    out  1      register file write enable
//  ALUsrcA     out  1      0=PC, 1=regA
//  ALUsrcB     out  2      0=regB, 1=const 4, 2=signext imm, 3=signext imm<<2
//  ALUControl  out  3      0=AND 1=OR 2=ADD 6=SUB 7=SLT
//  PCsrc       out  1      0=ALU result, 1=ALUOut
//  state       out  4      current state encoding (debug)
//  illegal     out  1      1-cycle pulse on unsupported Op/Funct
//  retired     out  CNT_W  count of completed instructions
// BEHAVIOUR
//  States (encoding): FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 ALUWB=7 BEQ=8
//   ADDIEX=9 ADDIWB=10. State register updates on posedge clk; outputs are combinational from state
//   (PCEn in BEQ also from Zero). Any output not listed for a state is 0.
//  FETCH : IorD=0 IRWrite=1 ALUsrcA=0 ALUsrcB=1 ALUControl=2 PCsrc=0 PCEn=1 -> DECODE
//  DECODE: ALUsrcA=0 ALUsrcB=3 ALUControl=2 (branch target into ALUOut).
//   LW/SW->MEMADR, RTYPE->EXEC, BEQ->BEQ, ADDI->ADDIEX (macro only); else illegal=1 -> FETCH
//  MEMADR: ALUsrcA=1 ALUsrcB=2 ALUControl=2; LW->MEMRD, SW->MEMWR
//  MEMRD : IorD=1 -> MEMWB;  MEMWB: RegDst=0 MemtoReg=1 RegWrite=1 -> FETCH
//  MEMWR : IorD=1 Memwrite=1 -> FETCH
//  EXEC  : ALUsrcA=1 ALUsrcB=0; Funct 20->2, 22->6, 24->0, 25->1, 2A->7 -> ALUWB;
//   other Funct: illegal=1, no writeback, -> FETCH
//  ALUWB : RegDst=1 MemtoReg=0 RegWrite=1 -> FETCH
//  BEQ   : ALUsrcA=1 ALUsrcB=0 ALUControl=6 PCsrc=1 PCEn=Zero -> FETCH
//  Latency incl. fetch: LW 5, SW 4, R 4, BEQ 3, ADDI 4, illegal 2 cycles.
//  retired +1 on clock edge leaving MEMWB, MEMWR, ALUWB, BEQ, ADDIWB (not illegal); wraps to 0 at max.
//  Reset: on posedge with rst=0 -> state=FETCH, retired=0. While rst=0, all outputs forced 0
//   (no PCEn/IRWrite/RegWrite/Memwrite). Reset mid-instruction aborts it; no partial writeback.
//  First cycle after rst returns to 1 is FETCH. Op/Funct sampled only in DECODE/MEMADR/EXEC.
//  Unreachable encodings (11-15): outputs 0, -> FETCH next cycle, no illegal pulse.
// CONFIGURATION
//  MC_ADDI_EN defined: ADDIEX: ALUsrcA=1 ALUsrcB=2 ALUControl=2 -> ADDIWB;
//   ADDIWB: RegDst=0 MemtoReg=0 RegWrite=1 -> FETCH.
//  MC_ADDI_EN undefined: states 9/10 absent; Op=OP_ADDI treated as illegal in DECODE.
// TESTING
//  rst=0 2 cycles, release -> state 0,1 on next edges; PCEn,IRWrite=1 only in FETCH; retired=0
//  Op=23 -> states 0,1,2,3,4; MEMRD IorD=1; MEMWB RegWrite=1 MemtoReg=1; retired 0->1
//  Op=2B -> states 0,1,2,5; Memwrite=1 exactly 1 cycle; RegWrite never 1
//  Op=0 Funct=22 -> EXEC ALUControl=6, ALUWB RegDst=1 RegWrite=1; Funct=3F -> illegal pulse, FETCH
//  Op=04 Zero=1 -> BEQ PCEn=1 PCsrc=1; Zero=0 -> PCEn=0; both retire (+1 each)
//  rst=0 asserted in MEMRD of LW -> no RegWrite, state=FETCH; Op=08 -> ADDIWB (EN) or illegal (no EN)

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// ============================================================================
// Module   : multicycle_control_fsm
// Brief    : Main controller for the multicycle MIPS datapath; one state per cycle.
//            Optional macro MC_ADDI_EN adds the ADDIEX/ADDIWB add-immediate path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_ADDI  = 6'h08,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  output logic             PCEn,
  output logic             IorD,
  output logic             Memwrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUsrcA,
  output logic [1:0]       ALUsrcB,
  output logic [2:0]       ALUControl,
  output logic             PCsrc,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BEQ    = 4'd8;
`ifdef MC_ADDI_EN
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
`endif

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;

  // Every control output is forced low while reset is held, so nothing is written mid-reset.
  always_comb begin
    PCEn       = 1'b0;
    IorD       = 1'b0;
    Memwrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUsrcA    = 1'b0;
    ALUsrcB    = 2'd0;
    ALUControl = 3'd0;
    PCsrc      = 1'b0;
    illegal    = 1'b0;
    w_next     = S_FETCH;
    w_retire   = 1'b0;
    if (rst) begin
      case (r_state)
        S_FETCH: begin
          IRWrite    = 1'b1;
          ALUsrcB    = 2'd1;
          ALUControl = ALU_ADD;
          PCEn       = 1'b1;
          w_next     = S_DECODE;
        end
        S_DECODE: begin
          ALUsrcB    = 2'd3;
          ALUControl = ALU_ADD;
          case (Op)
            OP_LW, OP_SW: w_next = S_MEMADR;
            OP_RTYPE:     w_next = S_EXEC;
            OP_BEQ:       w_next = S_BEQ;
`ifdef MC_ADDI_EN
            OP_ADDI:      w_next = S_ADDIEX;
`else
            OP_ADDI:      illegal = 1'b1;
`endif
            default:      illegal = 1'b1;
          endcase
        end
        S_MEMADR: begin
          ALUsrcA    = 1'b1;
          ALUsrcB    = 2'd2;
          ALUControl = ALU_ADD;
          w_next     = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          IorD   = 1'b1;
          w_next = S_MEMWB;
        end
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
          w_retire = 1'b1;
        end
        S_MEMWR: begin
          IorD     = 1'b1;
          Memwrite = 1'b1;
          w_retire = 1'b1;
        end
        S_EXEC: begin
          ALUsrcA = 1'b1;
          w_next  = S_ALUWB;
          case (Funct)
            6'h20:   ALUControl = ALU_ADD;
            6'h22:   ALUControl = ALU_SUB;
            6'h24:   ALUControl = ALU_AND;
            6'h25:   ALUControl = ALU_OR;
            6'h2A:   ALUControl = ALU_SLT;
            default: begin
              illegal = 1'b1;
              w_next  = S_FETCH;
            end
          endcase
        end
        S_ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
          w_retire = 1'b1;
        end
        S_BEQ: begin
          ALUsrcA    = 1'b1;
          ALUControl = ALU_SUB;
          PCsrc      = 1'b1;
          PCEn       = Zero;
          w_retire   = 1'b1;
        end
`ifdef MC_ADDI_EN
        S_ADDIEX: begin
          ALUsrcA    = 1'b1;
          ALUsrcB    = 2'd2;
          ALUControl = ALU_ADD;
          w_next     = S_ADDIWB;
        end
        S_ADDIWB: begin
          RegWrite = 1'b1;
          w_retire = 1'b1;
        end
`endif
        default: w_next = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end

  assign state   = r_state;
  assign retired = r_retired;

endmodule

`default_nettype wire
